// File: rtl/ctrl_pipe_stage.sv
// Control-word pipeline for a classic 5-stage core: ID/EX, EX/MEM and MEM/WB control
// registers with load-use bubble insertion and MEM-stage branch flush.
// Optional macro CTRL_PIPE_PERF_EN adds saturating stall/flush counters.
module ctrl_pipe_stage #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_regdst,
    input  logic                  id_branch,
    input  logic                  id_memread,
    input  logic                  id_memtoreg,
    input  logic                  id_memwrite,
    input  logic                  id_alusrc,
    input  logic                  id_regwrite,
    input  logic [1:0]            id_aluop,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  br_taken,
    output logic                  ex_valid,
    output logic                  ex_regdst,
    output logic                  ex_alusrc,
    output logic [1:0]            ex_aluop,
    output logic [REG_ADDR_W-1:0] ex_dst,
    output logic                  mem_valid,
    output logic                  mem_branch,
    output logic                  mem_memread,
    output logic                  mem_memwrite,
    output logic [REG_ADDR_W-1:0] mem_dst,
    output logic                  wb_valid,
    output logic                  wb_memtoreg,
    output logic                  wb_regwrite,
    output logic [REG_ADDR_W-1:0] wb_dst,
    output logic                  stall
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]      perf_stall_cnt,
    output logic [CNT_W-1:0]      perf_flush_cnt
`endif
);

    typedef struct packed {
        logic                  valid;
        logic                  regdst;
        logic                  branch;
        logic                  memread;
        logic                  memtoreg;
        logic                  memwrite;
        logic                  alusrc;
        logic                  regwrite;
        logic [1:0]            aluop;
        logic [REG_ADDR_W-1:0] dst;
        logic [REG_ADDR_W-1:0] rt;
    } idex_t;

    typedef struct packed {
        logic                  valid;
        logic                  branch;
        logic                  memread;
        logic                  memtoreg;
        logic                  memwrite;
        logic                  regwrite;
        logic [REG_ADDR_W-1:0] dst;
    } exmem_t;

    typedef struct packed {
        logic                  valid;
        logic                  memtoreg;
        logic                  regwrite;
        logic [REG_ADDR_W-1:0] dst;
    } memwb_t;

    if (CNT_W < 1 || REG_ADDR_W < 1) begin : g_param_check
        $error("ctrl_pipe_stage: CNT_W and REG_ADDR_W must be at least 1");
    end

    idex_t  id_word_s;
    idex_t  ex_d, ex_q;
    exmem_t mem_d, mem_q;
    memwb_t wb_d, wb_q;
    logic   hz_s;

    // Sanitised ID word: an unknown or low regdst selects rt so X never reaches dst
    always_comb begin
        id_word_s          = '0;
        id_word_s.valid    = 1'b1;
        id_word_s.branch   = id_branch;
        id_word_s.memread  = id_memread;
        id_word_s.memtoreg = id_memtoreg;
        id_word_s.memwrite = id_memwrite;
        id_word_s.alusrc   = id_alusrc;
        id_word_s.regwrite = id_regwrite;
        id_word_s.aluop    = id_aluop;
        id_word_s.rt       = id_rt;
        if (id_regdst == 1'b1) begin
            id_word_s.regdst = 1'b1;
            id_word_s.dst    = id_rd;
        end else begin
            id_word_s.regdst = 1'b0;
            id_word_s.dst    = id_rt;
        end
    end

    // Load-use detection against the load currently in EX
    always_comb begin
        hz_s = id_valid & ex_q.valid & ex_q.memread &
               ((ex_q.rt == id_rs) | (ex_q.rt == id_rt));
    end

    assign stall = hz_s & ~br_taken;

    // Next-state for all three stage registers; flush outranks the hazard bubble
    always_comb begin
        ex_d  = '0;
        mem_d = '0;
        wb_d  = '0;
        if (br_taken || hz_s || !id_valid) begin
            ex_d = '0;
        end else begin
            ex_d = id_word_s;
        end
        if (br_taken) begin
            mem_d = '0;
        end else begin
            mem_d.valid    = ex_q.valid;
            mem_d.branch   = ex_q.branch;
            mem_d.memread  = ex_q.memread;
            mem_d.memtoreg = ex_q.memtoreg;
            mem_d.memwrite = ex_q.memwrite;
            mem_d.regwrite = ex_q.regwrite;
            mem_d.dst      = ex_q.dst;
        end
        wb_d.valid    = mem_q.valid;
        wb_d.memtoreg = mem_q.memtoreg;
        wb_d.regwrite = mem_q.regwrite;
        wb_d.dst      = mem_q.dst;
    end

    // Stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_regdst    = ex_q.regdst;
    assign ex_alusrc    = ex_q.alusrc;
    assign ex_aluop     = ex_q.aluop;
    assign ex_dst       = ex_q.dst;
    assign mem_valid    = mem_q.valid;
    assign mem_branch   = mem_q.branch;
    assign mem_memread  = mem_q.memread;
    assign mem_memwrite = mem_q.memwrite;
    assign mem_dst      = mem_q.dst;
    assign wb_valid     = wb_q.valid;
    assign wb_memtoreg  = wb_q.memtoreg;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_dst       = wb_q.dst;

`ifdef CTRL_PIPE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (br_taken && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
